// File: rtl/even_down_counter.sv
// even_down_counter: even down counter by STEP with load/en/wrap_en in; count, tc, underflow, busy (COUNT state) out
module even_down_counter #(
  parameter int WIDTH = 4,
  parameter int STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             underflow,
  output logic             busy
);
  if (STEP % 2 != 0 || STEP < 2 || STEP >= 2 ** WIDTH) begin : g_bad_step
    $error("STEP must be even with 2 <= STEP < 2**WIDTH");
  end
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MAXE = '0 - STEP_V;
  state_t state;
  logic [WIDTH-1:0] ld;
  assign ld = load_val & ~{{(WIDTH-1){1'b0}}, 1'b1};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      tc <= 1'b0;
      underflow <= 1'b0;
      busy <= 1'b0;
    end else begin
      tc <= 1'b0;
      underflow <= 1'b0;
      if (load) begin
        count <= ld;
        state <= (ld == '0) ? DONE : COUNT;
        busy <= (ld != '0);
        tc <= (ld == '0);
      end else if (en && state == COUNT) begin
        count <= (count > STEP_V) ? count - STEP_V : '0;
        state <= (count > STEP_V) ? COUNT : DONE;
        busy <= (count > STEP_V);
        tc <= (count <= STEP_V);
      end else if (en && wrap_en && state == DONE) begin
        count <= MAXE;
        state <= COUNT;
        busy <= 1'b1;
        underflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_even_down_counter.sv
// tb_even_down_counter: checks default and WIDTH=6/STEP=4 counters against an arithmetic reference model
module tb_even_down_counter;
  typedef struct packed {
    int   cnt;
    logic run;
    logic fin;
    logic tc;
    logic uf;
  } mdl_t;
  logic clk = 1'b0;
  logic rst, load, en, wrap_en;
  logic [3:0] lv0, c0;
  logic [5:0] lv1, c1;
  logic tc0, uf0, b0, tc1, uf1, b1;
  int total = 0;
  int bad = 0;
  mdl_t m0, m1;
  always #5 clk = ~clk;
  even_down_counter dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv0), .en(en), .wrap_en(wrap_en),
    .count(c0), .tc(tc0), .underflow(uf0), .busy(b0)
  );
  even_down_counter #(.WIDTH(6), .STEP(4)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv1), .en(en), .wrap_en(wrap_en),
    .count(c1), .tc(tc1), .underflow(uf1), .busy(b1)
  );
  function automatic mdl_t mstep(mdl_t m, logic r, logic l, int lv, logic e, logic wr, int w, int s);
    mdl_t n;
    n = m;
    n.tc = 1'b0;
    n.uf = 1'b0;
    if (r) n = '0;
    else if (l) begin
      n.cnt = lv - lv % 2;
      n.run = n.cnt != 0;
      n.fin = n.cnt == 0;
      n.tc = n.cnt == 0;
    end else if (e && m.run) begin
      n.cnt = (m.cnt - s < 0) ? 0 : m.cnt - s;
      n.run = n.cnt != 0;
      n.fin = n.cnt == 0;
      n.tc = n.cnt == 0;
    end else if (e && m.fin && wr) begin
      n.cnt = (1 << w) - s;
      n.run = 1'b1;
      n.fin = 1'b0;
      n.uf = 1'b1;
    end
    return n;
  endfunction
  function automatic logic [6:0] exp0();
    return {m0.cnt[3:0], m0.tc, m0.uf, m0.run};
  endfunction
  function automatic logic [8:0] exp1();
    return {m1.cnt[5:0], m1.tc, m1.uf, m1.run};
  endfunction
  task automatic drive(logic r, logic l, int v, logic e, logic w);
    rst = r;
    load = l;
    lv0 = v[3:0];
    lv1 = v[5:0];
    en = e;
    wrap_en = w;
  endtask
  task automatic tick();
    @(posedge clk);
    m0 = mstep(m0, rst, load, int'(lv0), en, wrap_en, 4, 2);
    m1 = mstep(m1, rst, load, int'(lv1), en, wrap_en, 6, 4);
    #1;
  endtask
  task automatic test_reset();
    drive(1, 1, 10, 1, 1);
    tick();
    tick();
    total++;
    if ({c0, tc0, uf0, b0} !== 7'd0) begin
      bad++;
      $display("FAIL reset0: got %h want 0", {c0, tc0, uf0, b0});
    end
    total++;
    if ({c1, tc1, uf1, b1} !== 9'd0) begin
      bad++;
      $display("FAIL reset1: got %h want 0", {c1, tc1, uf1, b1});
    end
  endtask
  task automatic test_load_10();
    int seq[8] = '{10, 8, 6, 4, 2, 0, 0, 0};
    drive(0, 1, 10, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) drive(0, 0, 0, 1, 0);
      tick();
      total++;
      if ({c0, tc0, uf0, b0} !== {4'(seq[i]), i == 5, 1'b0, i < 5} || {c0, tc0, uf0, b0} !== exp0()) begin
        bad++;
        $display("FAIL load10[%0d]: got %h want %h", i, {c0, tc0, uf0, b0}, exp0());
      end
    end
  endtask
  task automatic test_odd_load();
    int seq[4] = '{6, 4, 2, 0};
    drive(0, 1, 7, 1, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) drive(0, 0, 0, 1, 0);
      tick();
      total++;
      if (c0 !== 4'(seq[i]) || c0[0] !== 1'b0 || tc0 !== (i == 3) || {c0, tc0, uf0, b0} !== exp0()) begin
        bad++;
        $display("FAIL odd[%0d]: got %h want %h", i, {c0, tc0, uf0, b0}, exp0());
      end
    end
  endtask
  task automatic test_wrap();
    int seq[13] = '{4, 2, 0, 14, 12, 10, 8, 6, 4, 2, 0, 14, 12};
    drive(0, 1, 4, 1, 1);
    for (int i = 0; i < 13; i++) begin
      if (i == 1) drive(0, 0, 0, 1, 1);
      tick();
      total++;
      if (c0 !== 4'(seq[i]) || tc0 !== (seq[i] == 0) || uf0 !== (i == 3 || i == 11) || (tc0 && uf0)
          || {c0, tc0, uf0, b0} !== exp0()) begin
        bad++;
        $display("FAIL wrap[%0d]: got %h want %h", i, {c0, tc0, uf0, b0}, exp0());
      end
    end
  endtask
  task automatic test_en_toggle();
    int seq[7] = '{12, 10, 10, 10, 8, 2, 0};
    logic ens[7] = '{0, 1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      drive(0, i == 0 || i == 5, i == 0 ? 12 : 2, ens[i], 0);
      tick();
      total++;
      if (c0 !== 4'(seq[i]) || tc0 !== (i == 6) || {c0, tc0, uf0, b0} !== exp0()) begin
        bad++;
        $display("FAIL entoggle[%0d]: got %h want %h", i, {c0, tc0, uf0, b0}, exp0());
      end
    end
  endtask
  task automatic test_back_to_back_rst();
    drive(0, 1, 14, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    repeat (3) tick();
    total++;
    if (c0 !== 4'd8 || b0 !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got count %0d busy %b want 8 1", c0, b0);
    end
    drive(1, 1, 6, 1, 1);
    tick();
    total++;
    if ({c0, tc0, uf0, b0} !== 7'd0 || {c0, tc0, uf0, b0} !== exp0()) begin
      bad++;
      $display("FAIL midrst: got %h want 0", {c0, tc0, uf0, b0});
    end
    drive(0, 0, 0, 1, 1);
    repeat (2) begin
      tick();
      total++;
      if ({c0, tc0, uf0, b0} !== 7'd0 || {c0, tc0, uf0, b0} !== exp0()) begin
        bad++;
        $display("FAIL idle_en: got %h want 0", {c0, tc0, uf0, b0});
      end
    end
  endtask
  task automatic test_param();
    int seq[5] = '{10, 6, 2, 0, 60};
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 10, 1, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive(0, 0, 0, 1, 0);
      if (i == 4) drive(0, 0, 0, 1, 1);
      tick();
      total++;
      if (c1 !== 6'(seq[i]) || tc1 !== (i == 3) || uf1 !== (i == 4) || {c1, tc1, uf1, b1} !== exp1()) begin
        bad++;
        $display("FAIL param[%0d]: got %h want %h", i, {c1, tc1, uf1, b1}, exp1());
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 40 == 0, $urandom % 6 == 0, int'($urandom % 64), $urandom % 4 != 0, $urandom % 2 == 1);
      tick();
      total++;
      if ({c0, tc0, uf0, b0} !== exp0() || (tc0 && uf0) || c0[0] !== 1'b0) begin
        bad++;
        $display("FAIL rand0[%0d]: got %h want %h", i, {c0, tc0, uf0, b0}, exp0());
      end
      total++;
      if ({c1, tc1, uf1, b1} !== exp1() || (tc1 && uf1) || c1[0] !== 1'b0) begin
        bad++;
        $display("FAIL rand1[%0d]: got %h want %h", i, {c1, tc1, uf1, b1}, exp1());
      end
    end
  endtask
  initial begin
    m0 = '0;
    m1 = '0;
    drive(1, 0, 0, 0, 0);
    test_reset();
    test_load_10();
    test_odd_load();
    test_wrap();
    test_en_toggle();
    test_back_to_back_rst();
    test_param();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/even_down_counter.md
Name: even_down_counter

Overview:
- Loadable, enable-gated even down counter: steps a WIDTH-bit value down by STEP (even) to zero.
- Flags terminal count and wrap-around.
- Counterpart of the team's even up counter, used for countdown timers and paced event generation.
- A 3-state FSM (IDLE/COUNT/DONE) gives start/finish status to the surrounding control logic.

Parameters:
- WIDTH, 4: counter width in bits.
- STEP, 2: decrement per enabled cycle. Must be even, 2 <= STEP < 2**WIDTH; checked at elaboration.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  load start value; highest priority after rst.
- load_val  input  WIDTH  start value; LSB is forced to 0 on load.
- en  input  1  count enable.
- wrap_en  input  1  1 = restart from max even value after zero; 0 = stop at zero.
- count  output  WIDTH  current count (registered).
- tc  output  1  one-cycle pulse, terminal count reached.
- underflow  output  1  one-cycle pulse, wrapped from 0 to max.
- busy  output  1  high while in COUNT.

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - count=0, tc=0, underflow=0, busy=0, state=IDLE.
  - Applies mid-count, and overrides load and en.
- MAXE = 2**WIDTH - STEP (14 for defaults).
- All outputs are registered. tc and underflow default to 0 every cycle unless set below.
- Priority order: rst > load > en > hold.
- load=1, any state:
  - count <= {load_val[WIDTH-1:1],1'b0}.
  - If the forced value != 0: state <= COUNT.
  - If it is 0: state <= DONE and tc <= 1.
  - en in the same cycle is ignored.
- IDLE: en is ignored and count holds 0. Only load leaves IDLE.
- COUNT, en=1:
  - If count > STEP: count <= count - STEP, stay COUNT.
  - If count <= STEP: count <= 0, tc <= 1, state <= DONE. This saturates and never goes negative, covering count < STEP when STEP > 2.
- COUNT, en=0: hold count and state. No pulses.
- DONE, en=1, wrap_en=1: count <= MAXE, underflow <= 1, state <= COUNT.
- DONE, en=1, wrap_en=0: hold count=0, no pulses; stays DONE until load or rst.
- DONE, en=0: hold.
- busy = (state==COUNT), registered with state. Timing of busy after load:
  - Load with nonzero value: busy=1 from the cycle after load.
  - Load with zero: busy stays 0.
- Latency: one clk from load/en sampling to updated count/flags. tc rises in the same cycle that count shows 0.
- tc and underflow are never high together.
- count is always even outside reset.
- Free-running sequence (wrap_en=1, en=1, load 14, defaults):
  - count: 14,12,10,8,6,4,2,0,14,12,...
  - tc pulses with each 0.
  - underflow pulses with each 0->14 step, one cycle after tc.
- en is a level, not a pulse: continuous en=1 decrements every cycle.

Test Plan:
- Reset, then load_val=4'd10, en=1, wrap_en=0 -> count 10,8,6,4,2,0. tc=1 only in the cycle count=0. busy 1->0 when count reaches 0. Count then holds 0 with en still high.
- load_val=4'd7 (odd), en=1 -> first count=6, then 4,2,0. tc once. count LSB never 1.
- wrap_en=1, load 4'd4, en=1 for 12 cycles -> 4,2,0,14,12,...,0,14. tc at each 0. underflow exactly in each 0->14 cycle. Never both in the same cycle.
- load 4'd12, en toggled 1,0,0,1 -> 10,10,10,8. Then load=1 and en=1 together with load_val=4'd2 -> count=2 (load wins). Next enabled cycle -> 0, tc=1.
- Mid-count rst: load 4'd14, 3 enabled cycles (count=8), then rst=1 with load=1 and en=1 -> next cycle count=0, busy=0, tc=0, underflow=0. en alone afterwards leaves count=0 (IDLE).
- Parameter override WIDTH=6, STEP=4: load 6'd10, en=1 -> 10,6,2,0 (saturating step). tc once. With wrap_en=1, next -> 60 and underflow=1.
